// File: rtl/ex_divider_if.sv
// EX-stage divider handshake bundle.
// EX drives the request side; the divider answers with stall and results.
interface ex_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_enable;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             annul;
  logic             stall_request;
  logic             busy;
  logic             result_valid;
  logic             divide_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_enable,
    output operand_a, operand_b, annul,
    input  stall_request, busy,
    input  result_valid, divide_by_zero,
    input  quotient, remainder
  );

  modport slave (
    input  start, signed_enable,
    input  operand_a, operand_b, annul,
    output stall_request, busy,
    output result_valid, divide_by_zero,
    output quotient, remainder
  );
endinterface

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// One quotient bit per cycle; stalls the pipe while running.
module ex_divider #(
  parameter int WIDTH = 32
) (
  input logic       clock,
  input logic       reset,
  ex_divider_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    a_neg = bus.signed_enable & bus.operand_a[WIDTH-1];
    b_neg = bus.signed_enable & bus.operand_b[WIDTH-1];
    a_abs = a_neg ? -bus.operand_a : bus.operand_a;
    b_abs = b_neg ? -bus.operand_b : bus.operand_b;
    // quotient bits shift into dvd as dividend bits leave it
    shifted  = {rem, dvd[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    qbit     = ~diff[WIDTH];
    rem_next = qbit ? diff[WIDTH-1:0]
                    : shifted[WIDTH-1:0];
    quo_next = {dvd[WIDTH-2:0], qbit};
  end

  assign bus.stall_request =
    ((state == IDLE) & bus.start) |
    (state == RUN);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      dvd                <= '0;
      dvs                <= '0;
      rem                <= '0;
      count              <= '0;
      q_neg              <= 1'b0;
      r_neg              <= 1'b0;
      bus.busy           <= 1'b0;
      bus.result_valid   <= 1'b0;
      bus.divide_by_zero <= 1'b0;
      bus.quotient       <= '0;
      bus.remainder      <= '0;
    end else if (bus.annul) begin
      state              <= IDLE;
      bus.busy           <= 1'b0;
      bus.result_valid   <= 1'b0;
      bus.divide_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.operand_b == '0) begin
              state              <= DONE;
              bus.quotient       <= '0;
              bus.remainder      <= '0;
              bus.divide_by_zero <= 1'b1;
              bus.result_valid   <= 1'b1;
            end else begin
              state    <= RUN;
              dvd      <= a_abs;
              dvs      <= b_abs;
              rem      <= '0;
              count    <= '0;
              q_neg    <= a_neg ^ b_neg;
              r_neg    <= a_neg;
              bus.busy <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd   <= quo_next;
          rem   <= rem_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            state              <= DONE;
            bus.busy           <= 1'b0;
            bus.result_valid   <= 1'b1;
            bus.divide_by_zero <= 1'b0;
            bus.quotient  <= q_neg ? -quo_next : quo_next;
            bus.remainder <= r_neg ? -rem_next : rem_next;
          end
        end
        DONE: begin
          if (!bus.start) begin
            state              <= IDLE;
            bus.result_valid   <= 1'b0;
            bus.divide_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_divider.sv
// Bench for ex_divider: transaction-level model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_ex_divider;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  ex_divider_if #(.WIDTH(32)) bus ();

  ex_divider #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // arithmetic reference: truncating division, remainder takes
  // the dividend's sign, results wrap to 32 bits
  function automatic void ref_div(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] q,
    output logic [31:0] r);
    longint la, lb;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = 32'(la / lb);
    r = 32'(la % lb);
  endfunction

  typedef enum {M_IDLE, M_CALC, M_HAVE} mphase_t;
  mphase_t     m_ph = M_IDLE;
  int          m_left = 0;
  logic [31:0] m_q = 0, m_r = 0, p_q, p_r;
  logic        m_valid = 0, m_dbz = 0;
  bit          chk_en = 0;

  always @(posedge clock) begin
    if (!reset) begin
      m_ph = M_IDLE;
      m_q = 0; m_r = 0;
      m_valid = 0; m_dbz = 0;
      chk_en = 1;
    end else if (bus.annul) begin
      m_ph = M_IDLE;
      m_valid = 0; m_dbz = 0;
    end else if (m_ph == M_IDLE) begin
      if (bus.start && bus.operand_b == 0) begin
        m_ph = M_HAVE;
        m_q = 0; m_r = 0;
        m_valid = 1; m_dbz = 1;
      end else if (bus.start) begin
        m_ph = M_CALC;
        m_left = 32;
        ref_div(bus.operand_a, bus.operand_b,
                bus.signed_enable, p_q, p_r);
      end
    end else if (m_ph == M_CALC) begin
      m_left--;
      if (m_left == 0) begin
        m_ph = M_HAVE;
        m_q = p_q; m_r = p_r;
        m_valid = 1; m_dbz = 0;
      end
    end else if (!bus.start) begin
      m_ph = M_IDLE;
      m_valid = 0; m_dbz = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_stall", 32'(bus.stall_request),
          32'((m_ph == M_IDLE && bus.start) ||
              m_ph == M_CALC));
      chk("m_busy", 32'(bus.busy), 32'(m_ph == M_CALC));
      chk("m_valid", 32'(bus.result_valid), 32'(m_valid));
      chk("m_dbz", 32'(bus.divide_by_zero), 32'(m_dbz));
      chk("m_quot", bus.quotient, m_q);
      chk("m_rem", bus.remainder, m_r);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s);
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.signed_enable = s;
    bus.start         = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (bus.result_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic s,
                         input logic [31:0] eq,
                         input logic [31:0] er,
                         input logic edbz,
                         input int elat);
    int lat;
    drive(a, b, s);
    #1 chk({tag, "_stall0"}, 32'(bus.stall_request), 1);
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dbz"}, 32'(bus.divide_by_zero), 32'(edbz));
    chk({tag, "_stall_done"}, 32'(bus.stall_request), 0);
    bus.start = 1'b0;
    tick();
    chk({tag, "_clr"}, 32'(bus.result_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.signed_enable = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.result_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_quot", bus.quotient, 0);
    reset = 1'b1;
    tick();

    run_div("u100_7", 100, 7, 0, 14, 2, 0, 33);
    run_div("s_m7_2", 32'hFFFF_FFF9, 2, 1,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 33);
    run_div("u_m7_2", 32'hFFFF_FFF9, 2, 0,
            32'h7FFF_FFFC, 1, 0, 33);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1,
            32'h8000_0000, 0, 0, 33);
    run_div("s_7_m2", 7, 32'hFFFF_FFFE, 1,
            32'hFFFF_FFFD, 1, 0, 33);
    run_div("s_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1,
            3, 32'hFFFF_FFFF, 0, 33);
    run_div("dbz", 5, 0, 0, 0, 0, 1, 1);
    run_div("u_max_1", 32'hFFFF_FFFF, 1, 0,
            32'hFFFF_FFFF, 0, 0, 33);
    run_div("u_3_max", 3, 32'hFFFF_FFFF, 0, 0, 3, 0, 33);

    // annul mid-run, together with a still-asserted start
    drive(1000, 3, 0);
    repeat (10) tick();
    bus.annul = 1'b1;
    #1 chk("ann_stall", 32'(bus.stall_request), 1);
    tick();
    bus.annul = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("ann_busy", 32'(bus.busy), 0);
    chk("ann_valid", 32'(bus.result_valid), 0);
    chk("ann_stall_after", 32'(bus.stall_request), 0);
    tick();
    run_div("after_ann", 9, 4, 0, 2, 1, 0, 33);

    // reset pulse in the middle of a run
    drive(50, 7, 0);
    repeat (15) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_stall", 32'(bus.stall_request), 0);
    chk("mid_rst_valid", 32'(bus.result_valid), 0);
    chk("mid_rst_quot", bus.quotient, 0);
    chk("mid_rst_rem", bus.remainder, 0);
    tick();

    // start held through DONE: result must hold, no restart
    drive(100, 9, 0);
    wait_valid(lat);
    chk("hold_lat", 32'(lat), 33);
    repeat (5) begin
      tick();
      chk("hold_valid", 32'(bus.result_valid), 1);
      chk("hold_q", bus.quotient, 11);
      chk("hold_r", bus.remainder, 1);
      chk("hold_stall", 32'(bus.stall_request), 0);
    end
    bus.start = 1'b0;
    tick();
    chk("hold_drop_valid", 32'(bus.result_valid), 0);
    chk("hold_drop_busy", 32'(bus.busy), 0);
    chk("hold_keep_q", bus.quotient, 11);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
